// File: rtl/alu_arbiter_pkg.sv
// Shared types for the alu_arbiter slice: ALU opcodes, requester id and operand bundle.
package alu_arbiter_pkg;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_ADDO = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_OR   = 4'b0100;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_AND  = 4'b0011;
  localparam logic [3:0] ALUC_NOR  = 4'b0101;
  localparam logic [3:0] ALUC_SLL  = 4'b1000;
  localparam logic [3:0] ALUC_MOVZ = 4'b1110;
  localparam logic [3:0] ALUC_MOVN = 4'b1100;

  typedef logic req_id_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  aluc;
  } alu_opnd_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both arbiter ports; MOVZ/MOVN pass a through and
// raise not_move when the move condition on b fails.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        zero,
  output logic        signal,
  output logic        not_move
);

  always_comb begin
    r        = '0;
    not_move = 1'b0;
    case (aluc)
      ALUC_ADD, ALUC_ADDO: r = a + b;
      ALUC_SUB:  r = a - b;
      ALUC_OR:   r = a | b;
      ALUC_XOR:  r = a ^ b;
      ALUC_AND:  r = a & b;
      ALUC_NOR:  r = ~(a | b);
      ALUC_SLL:  r = b << shamt;
      ALUC_MOVZ: begin
        r        = a;
        not_move = (b != 32'd0);
      end
      ALUC_MOVN: begin
        r        = a;
        not_move = (b == 32'd0);
      end
      default: begin
        r        = '0;
        not_move = 1'b0;
      end
    endcase
  end

  assign zero   = (r == 32'd0);
  assign signal = r[31];

endmodule

// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of one shared alu, single-entry response slot.
// Defining ALU_ARB_STATS_EN adds saturating per-port grant counters and stat_clr.
//   state | meaning
//   EMPTY | no response held, resp_valid=0
//   FULL  | response held on resp_*, waiting for resp_ready
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter int STAT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_a,
  input  logic [31:0] p0_b,
  input  logic [4:0]  p0_shamt,
  input  logic [3:0]  p0_aluc,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_a,
  input  logic [31:0] p1_b,
  input  logic [4:0]  p1_shamt,
  input  logic [3:0]  p1_aluc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_r,
  output logic        resp_zero,
  output logic        resp_signal,
`ifdef ALU_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1,
`endif
  output logic        resp_not_move
);

  typedef enum logic {EMPTY, FULL} slot_state_t;

  slot_state_t state;
  alu_opnd_t   opnd;
  req_id_t     last_grant;
  logic        free, p1_pri, win0, win1, acc0, acc1;

  if (STAT_W < 1) begin : g_bad_stat_w
    $error("alu_arbiter: STAT_W must be at least 1");
  end

  assign resp_valid = (state == FULL);
  assign free       = !resp_valid || resp_ready;

  // Port 1 only takes a contended cycle when round-robin is on and port 0 went last.
  assign p1_pri   = RR_EN && (last_grant == 1'b0);
  assign win0     = p0_valid && !(p1_valid && p1_pri);
  assign win1     = p1_valid && !win0;
  assign p0_ready = win0 && free && !rst;
  assign p1_ready = win1 && free && !rst;
  assign acc0     = p0_valid && p0_ready;
  assign acc1     = p1_valid && p1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      opnd       <= '0;
      resp_id    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (acc0) begin
        opnd       <= '{a: p0_a, b: p0_b, shamt: p0_shamt, aluc: p0_aluc};
        resp_id    <= 1'b0;
        last_grant <= 1'b0;
      end else if (acc1) begin
        opnd       <= '{a: p1_a, b: p1_b, shamt: p1_shamt, aluc: p1_aluc};
        resp_id    <= 1'b1;
        last_grant <= 1'b1;
      end
      case (state)
        EMPTY:   if (acc0 || acc1) state <= FULL;
        FULL:    if (!(acc0 || acc1) && resp_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

  alu u_alu (
    .a        (opnd.a),
    .b        (opnd.b),
    .shamt    (opnd.shamt),
    .aluc     (opnd.aluc),
    .r        (resp_r),
    .zero     (resp_zero),
    .signal   (resp_signal),
    .not_move (resp_not_move)
  );

`ifdef ALU_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
    end else begin
      if (acc0 && stat_grant0 != STAT_MAX) stat_grant0 <= stat_grant0 + 1'b1;
      if (acc1 && stat_grant1 != STAT_MAX) stat_grant1 <= stat_grant1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then random traffic against a
// transaction-level model of the slot, arbitration and ALU.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam bit RR     = 1'b1;
  localparam int STAT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_ready, p1_valid, p1_ready;
  logic [31:0] p0_a, p0_b, p1_a, p1_b;
  logic [4:0]  p0_shamt, p1_shamt;
  logic [3:0]  p0_aluc, p1_aluc;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_signal, resp_not_move;
  logic [31:0] resp_r;
`ifdef ALU_ARB_STATS_EN
  logic              stat_clr;
  logic [STAT_W-1:0] stat_grant0, stat_grant1;
  int unsigned       m_s0, m_s1;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(RR), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_a(p0_a), .p0_b(p0_b),
    .p0_shamt(p0_shamt), .p0_aluc(p0_aluc),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_a(p1_a), .p1_b(p1_b),
    .p1_shamt(p1_shamt), .p1_aluc(p1_aluc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_r(resp_r), .resp_zero(resp_zero), .resp_signal(resp_signal),
`ifdef ALU_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
`endif
    .resp_not_move(resp_not_move)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: what the slot holds, who went last, and which requests are still pending.
  bit          m_valid, m_id, m_last;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_sh;
  logic [3:0]  m_op;
  bit          e_rdy0, e_rdy1, pend0, pend1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_vec++;
    if (obs !== expd) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expd, $time);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output bit nm);
    r  = 32'd0;
    nm = 1'b0;
    case (op)
      4'b0000, 4'b0010: r = a + b;
      4'b0001: r = a - b;
      4'b0100: r = a | b;
      4'b0110: r = a ^ b;
      4'b0011: r = a & b;
      4'b0101: r = ~(a | b);
      4'b1000: r = b * (32'd1 << sh);
      4'b1110: begin r = a; nm = (b != 0); end
      4'b1100: begin r = a; nm = (b == 0); end
      default: begin r = 32'd0; nm = 1'b0; end
    endcase
  endfunction

  // One clock: check readys before the edge, advance the model at the edge, check outputs after.
  task automatic step();
    bit          w0, w1, free, acc0, acc1, enm;
    logic [31:0] er;
    #1;
    free = !m_valid || resp_ready;
    if (p0_valid && p1_valid) w0 = RR ? m_last : 1'b1;
    else                      w0 = p0_valid;
    w1 = p1_valid && !w0;
    e_rdy0 = w0 && free && !rst;
    e_rdy1 = w1 && free && !rst;
    chk("p0_ready", p0_ready, e_rdy0);
    chk("p1_ready", p1_ready, e_rdy1);
    @(posedge clk);
    acc0 = p0_valid && e_rdy0;
    acc1 = p1_valid && e_rdy1;
    if (rst) begin
      m_valid = 0; m_id = 0; m_last = 1;
      m_a = 0; m_b = 0; m_sh = 0; m_op = 0;
    end else if (acc0) begin
      m_valid = 1; m_id = 0; m_last = 0;
      m_a = p0_a; m_b = p0_b; m_sh = p0_shamt; m_op = p0_aluc;
    end else if (acc1) begin
      m_valid = 1; m_id = 1; m_last = 1;
      m_a = p1_a; m_b = p1_b; m_sh = p1_shamt; m_op = p1_aluc;
    end else if (resp_ready) begin
      m_valid = 0;
    end
    pend0 = p0_valid && !acc0;
    pend1 = p1_valid && !acc1;
`ifdef ALU_ARB_STATS_EN
    if (rst || stat_clr) begin
      m_s0 = 0; m_s1 = 0;
    end else begin
      if (acc0 && m_s0 < (2 ** STAT_W) - 1) m_s0++;
      if (acc1 && m_s1 < (2 ** STAT_W) - 1) m_s1++;
    end
`endif
    @(negedge clk);
    ref_alu(m_op, m_a, m_b, m_sh, er, enm);
    chk("resp_valid", resp_valid, m_valid);
    chk("resp_id", resp_id, m_id);
    chk("resp_not_move", resp_not_move, enm);
    if (!enm) begin
      chk("resp_r", resp_r, er);
      chk("resp_zero", resp_zero, er == 0);
      chk("resp_signal", resp_signal, er[31]);
    end
`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0", stat_grant0, m_s0);
    chk("stat_grant1", stat_grant1, m_s1);
`endif
  endtask

  task automatic rand_port(output logic v, output logic [31:0] a, output logic [31:0] b,
                           output logic [4:0] sh, output logic [3:0] op);
    v  = ($urandom_range(0, 2) != 0);
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    sh = 5'($urandom_range(0, 31));
    op = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst = 1; resp_ready = 0;
    p0_valid = 0; p0_a = 0; p0_b = 0; p0_shamt = 0; p0_aluc = 0;
    p1_valid = 0; p1_a = 0; p1_b = 0; p1_shamt = 0; p1_aluc = 0;
    m_valid = 0; m_id = 0; m_last = 1; m_a = 0; m_b = 0; m_sh = 0; m_op = 0;
    pend0 = 0; pend1 = 0;
`ifdef ALU_ARB_STATS_EN
    stat_clr = 0; m_s0 = 0; m_s1 = 0;
`endif
    @(negedge clk);
    p0_valid = 1;
    step();
    chk("reset_valid", resp_valid, 0);
    chk("reset_zero", resp_zero, 1);
    chk("reset_r", resp_r, 0);

    // Single SUB on port 0
    rst = 0; resp_ready = 1;
    p0_valid = 1; p0_a = 5; p0_b = 3; p0_shamt = 0; p0_aluc = ALUC_SUB;
    step();
    chk("sub_valid", resp_valid, 1);
    chk("sub_id", resp_id, 0);
    chk("sub_r", resp_r, 2);
    chk("sub_zero", resp_zero, 0);
    p0_valid = 0;
    step();
    chk("sub_drain", resp_valid, 0);

    // Contention after reset: grants alternate starting with port 0
    rst = 1; step(); rst = 0;
    p0_valid = 1; p0_a = 10; p0_b = 1; p0_aluc = ALUC_ADD;
    p1_valid = 1; p1_a = 20; p1_b = 2; p1_aluc = ALUC_ADD;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_valid", resp_valid, 1);
      chk("rr_id", resp_id, i % 2);
    end
    p0_valid = 0; p1_valid = 0;
    step();

    // Backpressure with a held SLL response
    p1_valid = 1; p1_a = 0; p1_b = 1; p1_shamt = 4; p1_aluc = ALUC_SLL;
    step();
    p1_valid = 0; resp_ready = 0;
    p0_valid = 1; p0_a = 7; p0_b = 8; p0_aluc = ALUC_ADD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_r", resp_r, 16);
      chk("bp_id", resp_id, 1);
    end
    resp_ready = 1;
    #1 chk("bp_release_ready", p0_ready, 1);
    step();
    chk("bp_next_r", resp_r, 15);
    chk("bp_next_id", resp_id, 0);

    // Conditional moves
    p0_a = 32'hABCD; p0_b = 0; p0_aluc = ALUC_MOVZ;
    step();
    chk("movz_r", resp_r, 32'hABCD);
    chk("movz_nm", resp_not_move, 0);
    p0_b = 1;
    step();
    chk("movz_b1_nm", resp_not_move, 1);
    p0_b = 0; p0_aluc = ALUC_MOVN;
    step();
    chk("movn_b0_nm", resp_not_move, 1);
    p0_valid = 0;
    step();

    // Reset while a response is held; request in the reset cycle is dropped
    p0_valid = 1; p0_a = 1; p0_b = 1; p0_aluc = ALUC_ADD;
    step();
    resp_ready = 0; rst = 1; p1_valid = 1; p1_a = 3; p1_b = 4; p1_aluc = ALUC_OR;
    step();
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_r", resp_r, 0);
    chk("midrst_zero", resp_zero, 1);
    rst = 0; resp_ready = 1;
    step();
    chk("midrst_first_id", resp_id, 0);
    p0_valid = 0; p1_valid = 0;
    step();

    // Random traffic honouring the hold-until-accepted rule
    for (int i = 0; i < 3000; i++) begin
      if (!pend0) rand_port(p0_valid, p0_a, p0_b, p0_shamt, p0_aluc);
      if (!pend1) rand_port(p1_valid, p1_a, p1_b, p1_shamt, p1_aluc);
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    p0_valid = 0; p1_valid = 0; resp_ready = 1;
    step();

`ifdef ALU_ARB_STATS_EN
    p0_valid = 1; p0_a = 1; p0_b = 2; p0_aluc = ALUC_ADD;
    for (int i = 0; i < 70000; i++) step();
    chk("stat_sat", stat_grant0, 32'hFFFF);
    stat_clr = 1;
    step();
    chk("stat_clr_grant", stat_grant0, 0);
    stat_clr = 0;
    p0_valid = 0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
